// File: rtl/sample_link_framer.sv
// Sample link framer: periodically captures CHANNELS x DATA_W samples and streams them as
// a byte frame: HEADER, seq, payload (channel 0 first, MSB byte first), checksum.
module sample_link_framer #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned SAMPLE_PERIOD = 720,
    parameter logic [7:0]  HEADER        = 8'hA5
) (
    input  logic                         clock,
    input  logic                         resetN,
    input  logic                         sync_in,
    input  logic [CHANNELS*DATA_W-1:0]   ad,
    input  logic                         out_ready,
    output logic [7:0]                   out_data,
    output logic                         out_valid,
    output logic                         out_sof,
    output logic                         armed,
    output logic                         overrun,
    output logic [7:0]                   seq
);

    localparam int unsigned PAY_BYTES = CHANNELS * DATA_W / 8;
    localparam int unsigned BPS       = DATA_W / 8;
    localparam int unsigned CNT_W     = $clog2(SAMPLE_PERIOD);
    localparam int unsigned IDX_W     = 6;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAY_BYTES - 1);

    typedef enum logic [2:0] {StIdle, StHdr, StSeq, StPay, StCsum} state_e;

    state_e                       r_state;
    state_e                       w_state_next;
    logic [CNT_W-1:0]             r_cnt;
    logic                         r_armed;
    logic [7:0]                   r_seq;
    logic [7:0]                   r_seq_next;
    logic [CHANNELS*DATA_W-1:0]   r_payload;
    logic                         r_overrun;
    logic [IDX_W-1:0]             r_idx;
    logic [IDX_W-1:0]             w_idx_next;
    logic                         w_tick;
    logic                         w_xfer;
    logic                         w_accept;
    logic [7:0]                   w_csum;
    logic [7:0]                   w_pay_byte;

    // Tick on the arming edge, then whenever the running counter is back at 0.
    always_comb begin
        w_tick = sync_in && (!r_armed || (r_cnt == '0));
        w_xfer = out_valid && out_ready;
    end

    // Arm/disarm control and the free-running sample period counter.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_armed <= 1'b0;
            r_cnt   <= '0;
        end else if (!sync_in) begin
            r_armed <= 1'b0;
            r_cnt   <= '0;
        end else if (!r_armed) begin
            r_armed <= 1'b1;
            r_cnt   <= CNT_W'(1);
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Next-state logic; a tick is accepted in IDLE or alongside the final checksum transfer.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_accept     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_tick) begin
                    w_accept     = 1'b1;
                    w_state_next = StHdr;
                end
            end
            StHdr: begin
                if (w_xfer) w_state_next = StSeq;
            end
            StSeq: begin
                if (w_xfer) begin
                    w_state_next = StPay;
                    w_idx_next   = '0;
                end
            end
            StPay: begin
                if (w_xfer) begin
                    if (r_idx == IDX_LAST) w_state_next = StCsum;
                    else                   w_idx_next   = r_idx + 1'b1;
                end
            end
            StCsum: begin
                if (w_xfer) begin
                    if (w_tick) begin
                        w_accept     = 1'b1;
                        w_state_next = StHdr;
                    end else begin
                        w_state_next = StIdle;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // FSM state, payload capture, sequence numbering and sticky overrun.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state    <= StIdle;
            r_idx      <= '0;
            r_payload  <= '0;
            r_seq      <= 8'd0;
            r_seq_next <= 8'd0;
            r_overrun  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            if (w_accept) begin
                r_payload  <= ad;
                r_seq      <= r_seq_next;
                r_seq_next <= r_seq_next + 8'd1;
            end
            if (w_tick && !w_accept) r_overrun <= 1'b1;
        end
    end

    // Payload byte select (channel-major, MSB byte first) and running checksum.
    always_comb begin
        w_pay_byte = 8'd0;
        w_csum     = r_seq;
        for (int j = 0; j < int'(PAY_BYTES); j++) begin
            if (r_idx == IDX_W'(j)) begin
                w_pay_byte = r_payload[(j / int'(BPS)) * int'(DATA_W)
                                       + (int'(BPS) - 1 - (j % int'(BPS))) * 8 +: 8];
            end
            w_csum = w_csum + r_payload[j*8 +: 8];
        end
    end

    // Output byte mux driven straight from the registered state.
    always_comb begin
        out_valid = (r_state != StIdle);
        out_sof   = (r_state == StHdr);
        out_data  = 8'd0;
        unique case (r_state)
            StHdr:   out_data = HEADER;
            StSeq:   out_data = r_seq;
            StPay:   out_data = w_pay_byte;
            StCsum:  out_data = w_csum;
            default: out_data = 8'd0;
        endcase
    end

    assign armed   = r_armed;
    assign overrun = r_overrun;
    assign seq     = r_seq;

endmodule

// File: tb/tb_sample_link_framer.sv
// Directed bench for sample_link_framer: CHANNELS=2/DATA_W=8 main instance plus a
// DATA_W=16/CHANNELS=1 instance for the wide-sample byte order.
module tb_sample_link_framer;

    logic        clock;
    logic        resetN;
    logic        sync_in;
    logic [15:0] ad;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_sof;
    logic        armed;
    logic        overrun;
    logic [7:0]  seq;

    logic        w16_sync;
    logic [15:0] w16_ad;
    logic        w16_ready;
    logic [7:0]  w16_data;
    logic        w16_valid;
    logic        w16_sof;
    logic        w16_armed;
    logic        w16_overrun;
    logic [7:0]  w16_seq;

    int checks   = 0;
    int failures = 0;
    int spurious = 0;

    sample_link_framer #(
        .DATA_W(8), .CHANNELS(2), .SAMPLE_PERIOD(16), .HEADER(8'hA5)
    ) u_dut (
        .clock(clock), .resetN(resetN), .sync_in(sync_in), .ad(ad), .out_ready(out_ready),
        .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof), .armed(armed),
        .overrun(overrun), .seq(seq)
    );

    sample_link_framer #(
        .DATA_W(16), .CHANNELS(1), .SAMPLE_PERIOD(16), .HEADER(8'hA5)
    ) u_dut16 (
        .clock(clock), .resetN(resetN), .sync_in(w16_sync), .ad(w16_ad),
        .out_ready(w16_ready), .out_data(w16_data), .out_valid(w16_valid),
        .out_sof(w16_sof), .armed(w16_armed), .overrun(w16_overrun), .seq(w16_seq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetN    = 1'b1;
        sync_in   = 1'b0;
        ad        = 16'h2120;
        out_ready = 1'b1;
        w16_sync  = 1'b0;
        w16_ad    = 16'hBEEF;
        w16_ready = 1'b1;
        #2 resetN = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_sof", 32'(out_sof), 32'h0);
        chk("rst_armed", 32'(armed), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_seq", 32'(seq), 32'h0);
        tick();
        tick();
        resetN = 1'b1;
        tick();
        chk("idle_no_sync", 32'(out_valid), 32'h0);

        // Basic frame: A5,00,20,21,41
        sync_in = 1'b1;
        tick();
        chk("f0_hdr", 32'(out_data), 32'hA5);
        chk("f0_sof", 32'(out_sof), 32'h1);
        chk("f0_valid", 32'(out_valid), 32'h1);
        chk("f0_armed", 32'(armed), 32'h1);
        chk("f0_seq", 32'(seq), 32'h00);
        tick(); chk("f0_seqbyte", 32'(out_data), 32'h00);
        chk("f0_sof_off", 32'(out_sof), 32'h0);
        tick(); chk("f0_pay0", 32'(out_data), 32'h20);
        tick(); chk("f0_pay1", 32'(out_data), 32'h21);
        tick(); chk("f0_csum", 32'(out_data), 32'h41);
        tick(); chk("f0_done", 32'(out_valid), 32'h0);
        repeat (10) tick();
        chk("f1_not_early", 32'(out_valid), 32'h0);

        // Second frame 16 clocks after first header, with backpressure during SEQ
        tick();
        chk("f1_hdr", 32'(out_data), 32'hA5);
        chk("f1_seq", 32'(seq), 32'h01);
        tick(); chk("f1_seqbyte", 32'(out_data), 32'h01);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_data", 32'(out_data), 32'h01);
            chk("bp_hold_valid", 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        tick(); chk("f1_pay0", 32'(out_data), 32'h20);
        tick(); chk("f1_pay1", 32'(out_data), 32'h21);
        tick(); chk("f1_csum", 32'(out_data), 32'h42);
        tick(); chk("f1_done", 32'(out_valid), 32'h0);

        // Overrun: stall 20 cycles from header so the next tick is dropped
        repeat (6) tick();
        chk("f2_hdr", 32'(out_data), 32'hA5);
        chk("f2_seq", 32'(seq), 32'h02);
        out_ready = 1'b0;
        repeat (15) tick();
        chk("ovr_not_yet", 32'(overrun), 32'h0);
        tick();
        chk("ovr_set", 32'(overrun), 32'h1);
        chk("ovr_seq_kept", 32'(seq), 32'h02);
        chk("ovr_hdr_held", 32'(out_data), 32'hA5);
        repeat (4) tick();
        out_ready = 1'b1;
        tick(); chk("f2_seqbyte", 32'(out_data), 32'h02);
        tick(); chk("f2_pay0", 32'(out_data), 32'h20);
        tick(); chk("f2_pay1", 32'(out_data), 32'h21);
        tick(); chk("f2_csum", 32'(out_data), 32'h43);
        tick(); chk("f2_done", 32'(out_valid), 32'h0);
        repeat (7) tick();
        chk("f3_hdr", 32'(out_data), 32'hA5);
        chk("f3_seq_after_drop", 32'(seq), 32'h03);
        chk("ovr_sticky", 32'(overrun), 32'h1);

        // Reset mid-PAY aborts immediately
        tick();
        tick(); chk("f3_pay0", 32'(out_data), 32'h20);
        resetN = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(out_valid), 32'h0);
        chk("rst_mid_overrun", 32'(overrun), 32'h0);
        chk("rst_mid_seq", 32'(seq), 32'h00);
        chk("rst_mid_armed", 32'(armed), 32'h0);
        #2 resetN = 1'b1;
        tick();
        chk("r0_hdr", 32'(out_data), 32'hA5);
        chk("r0_seq", 32'(seq), 32'h00);
        chk("r0_overrun", 32'(overrun), 32'h0);

        // CSUM transfer coinciding with a tick goes straight to HDR
        out_ready = 1'b0;
        repeat (11) tick();
        out_ready = 1'b1;
        tick(); chk("r0_seqbyte", 32'(out_data), 32'h00);
        tick(); chk("r0_pay0", 32'(out_data), 32'h20);
        tick(); chk("r0_pay1", 32'(out_data), 32'h21);
        tick(); chk("r0_csum", 32'(out_data), 32'h41);
        tick();
        chk("b2b_hdr", 32'(out_data), 32'hA5);
        chk("b2b_sof", 32'(out_sof), 32'h1);
        chk("b2b_seq", 32'(seq), 32'h01);
        chk("b2b_no_overrun", 32'(overrun), 32'h0);

        // ad changes after capture must not leak into the in-flight frame
        ad = 16'h7F01;
        tick(); chk("r1_seqbyte", 32'(out_data), 32'h01);
        tick(); chk("r1_pay0_stable", 32'(out_data), 32'h20);
        tick(); chk("r1_pay1_stable", 32'(out_data), 32'h21);
        tick(); chk("r1_csum", 32'(out_data), 32'h42);
        tick(); chk("r1_done", 32'(out_valid), 32'h0);

        // Disarm during PAY: frame completes, then silence
        repeat (11) tick();
        chk("r2_hdr", 32'(out_data), 32'hA5);
        chk("r2_seq", 32'(seq), 32'h02);
        tick(); chk("r2_seqbyte", 32'(out_data), 32'h02);
        tick(); chk("r2_pay0", 32'(out_data), 32'h01);
        sync_in = 1'b0;
        tick();
        chk("r2_pay1", 32'(out_data), 32'h7F);
        chk("disarm_armed", 32'(armed), 32'h0);
        tick(); chk("r2_csum", 32'(out_data), 32'h82);
        tick(); chk("r2_done", 32'(out_valid), 32'h0);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) spurious++;
        end
        chk("no_frames_after_disarm", 32'(spurious), 32'h0);
        chk("disarm_seq_kept", 32'(seq), 32'h02);

        // Sequence wrap FF -> 00
        sync_in = 1'b1;
        tick();
        chk("g0_seq", 32'(seq), 32'h03);
        for (int i = 0; i < 252; i++) repeat (16) tick();
        chk("wrap_hdr_ff", 32'(out_data), 32'hA5);
        chk("wrap_seq_ff", 32'(seq), 32'hFF);
        repeat (16) tick();
        chk("wrap_seq_00", 32'(seq), 32'h00);
        chk("wrap_no_overrun", 32'(overrun), 32'h0);

        // 16-bit sample instance: A5,00,BE,EF,AD
        w16_sync = 1'b1;
        tick(); chk("w16_hdr", 32'(w16_data), 32'hA5);
        chk("w16_sof", 32'(w16_sof), 32'h1);
        tick(); chk("w16_seqbyte", 32'(w16_data), 32'h00);
        tick(); chk("w16_msb", 32'(w16_data), 32'hBE);
        tick(); chk("w16_lsb", 32'(w16_data), 32'hEF);
        tick(); chk("w16_csum", 32'(w16_data), 32'hAD);
        tick(); chk("w16_done", 32'(w16_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
